adder_serial_sched: RTL

- Time-shares one instance of the 1-bit hard `adder` cell (a, b, cin -> cout, sumout) among NREQ requesters.
- Each granted request adds two WIDTH-bit operands bit-serially, LSB first, one bit per clock. The carry is kept in a flop between cycles.
- Sits in front of the hard-adder primitive. Lets area-constrained logic get full-width sums from a single carry cell.

---
 rtl/adder_serial_sched.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/adder_serial_sched.sv
// Round-robin scheduler that time-shares one 1-bit adder cell among NREQ requesters, adding LSB first.
// Latency: accept in cycle 0, WIDTH serial cycles, result valid from cycle WIDTH+1.
// Backpressure: result held in DONE until rsp_ready; no request is accepted outside IDLE.
`timescale 1ns/1ps

module adder_serial_sched #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_cin,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout,
    output logic                  busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_shift;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [IDW-1:0]   id;
    logic [IDW-1:0]   last_grant;
    logic [IDW-1:0]   grant;
    logic             grant_vld;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             sel_cin;
    logic             add_cout;
    logic             add_sum;
    logic             last_bit;

    adder u_adder (
        .a      (a_sh[0]),
        .b      (b_sh[0]),
        .cin    (carry),
        .cout   (add_cout),
        .sumout (add_sum)
    );

    assign last_bit = (cnt == CW'(WIDTH - 1));

    // Search starts one past the previous winner so every waiting requester is reached within NREQ grants.
    always_comb begin
        int k;
        grant_vld = 1'b0;
        grant     = '0;
        k         = 0;
        for (int i = 1; i <= NREQ; i++) begin
            k = (int'(last_grant) + i) % NREQ;
            if (!grant_vld && req_valid[k]) begin
                grant_vld = 1'b1;
                grant     = IDW'(k);
            end
        end
    end

    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        sel_cin = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant == IDW'(k)) begin
                sel_a   = req_a[k*WIDTH +: WIDTH];
                sel_b   = req_b[k*WIDTH +: WIDTH];
                sel_cin = req_cin[k];
            end
        end
    end

    always_comb begin
        sum_shift            = sum_sh >> 1;
        sum_shift[WIDTH-1]   = add_sum;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_vld) state_nxt = RUN;
            RUN:     if (last_bit)  state_nxt = DONE;
            DONE:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = 1'b0;
        rsp_sum   = '0;
        rsp_cout  = 1'b0;
        rsp_id    = '0;
        busy      = (state != IDLE);
        if (state == IDLE && grant_vld) begin
            req_ready[grant] = 1'b1;
        end
        if (state == DONE) begin
            rsp_valid = 1'b1;
            rsp_sum   = sum_sh;
            rsp_cout  = carry;
            rsp_id    = id;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh       <= '0;
            b_sh       <= '0;
            sum_sh     <= '0;
            carry      <= 1'b0;
            cnt        <= '0;
            id         <= '0;
            last_grant <= IDW'(NREQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        a_sh       <= sel_a;
                        b_sh       <= sel_b;
                        carry      <= sel_cin;
                        id         <= grant;
                        last_grant <= grant;
                        cnt        <= '0;
                    end
                end
                RUN: begin
                    carry  <= add_cout;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= sum_shift;
                    cnt    <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// Behavioural stand-in for the hard 1-bit full-adder cell.
module adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic cout,
    output logic sumout
);

    assign sumout = a ^ b ^ cin;
    assign cout   = (a & b) | (a & cin) | (b & cin);

endmodule
